// File: rtl/membus_arbiter.sv
// -----------------------------------------------------------------------------
// membus_arbiter
//
// Two-master arbiter for the tagged memory bus. The CPU is master 0 (m0) and
// the I/O-DMA channel is master 1 (m1). One master owns the bus for a whole
// transaction: address strobe plus one data cycle, or astb + rd + wr for an
// atomic read-modify-write. The owner's ad/tag/strobes are muxed straight
// through to memory, gated by the transaction phase. A granted master that
// makes no progress for TIMEOUT cycles is aborted, and its time-out output
// pulses for one cycle.
//
// Parameters
//   TIMEOUT  cycles without progress before the owner is aborted (2..65535)
//   RR       1 = round-robin between masters, 0 = fixed priority (m0 wins)
//
// Ports
//   clk, reset_n                    clock; asynchronous active-low reset
//   mX_req                          master X requests the bus (held for the transaction)
//   mX_ad[63:0], mX_tag[7:0]        address (astb cycle) / write data and tag
//   mX_astb, mX_atomic              address strobe; atomic flag sampled with astb
//   mX_rd, mX_wr                    read / write data cycle
//   mX_gnt                          master X owns the bus
//   mX_timeout                      one-cycle pulse: X's transaction was aborted
//   o_ad, o_tag                     owner's ad/tag to memory, 0 when idle
//   o_astb, o_atomic, o_rd, o_wr    owner's strobes, gated by phase
//   o_busy                          bus owned
// -----------------------------------------------------------------------------
module membus_arbiter #(
    parameter int TIMEOUT = 256,
    parameter bit RR      = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_req,
    input  logic [63:0] m0_ad,
    input  logic [7:0]  m0_tag,
    input  logic        m0_astb,
    input  logic        m0_atomic,
    input  logic        m0_rd,
    input  logic        m0_wr,
    output logic        m0_gnt,
    output logic        m0_timeout,

    input  logic        m1_req,
    input  logic [63:0] m1_ad,
    input  logic [7:0]  m1_tag,
    input  logic        m1_astb,
    input  logic        m1_atomic,
    input  logic        m1_rd,
    input  logic        m1_wr,
    output logic        m1_gnt,
    output logic        m1_timeout,

    output logic [63:0] o_ad,
    output logic [7:0]  o_tag,
    output logic        o_astb,
    output logic        o_atomic,
    output logic        o_rd,
    output logic        o_wr,
    output logic        o_busy
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no owner
        ADDR = 2'd1,   // granted, awaiting astb
        DATA = 2'd2,   // awaiting rd or wr
        LOCK = 2'd3    // atomic read done, awaiting wr
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;     // 0 = m0, 1 = m1
    logic            last_q,  last_d;      // last master granted
    logic            atomic_q, atomic_d;   // atomic flag latched with astb
    logic [CW-1:0]   cnt_q,   cnt_d;       // cycles spent in the current state
    logic [1:0]      tout_q,  tout_d;      // per-master time-out pulse

    // Owner-selected master inputs. The select is the registered owner, so
    // the path from master to memory adds no latency.
    logic        sel_req, sel_astb, sel_atomic, sel_rd, sel_wr;
    logic [63:0] sel_ad;
    logic [7:0]  sel_tag;

    always_comb begin
        sel_req    = owner_q ? m1_req    : m0_req;
        sel_astb   = owner_q ? m1_astb   : m0_astb;
        sel_atomic = owner_q ? m1_atomic : m0_atomic;
        sel_rd     = owner_q ? m1_rd     : m0_rd;
        sel_wr     = owner_q ? m1_wr     : m0_wr;
        sel_ad     = owner_q ? m1_ad     : m0_ad;
        sel_tag    = owner_q ? m1_tag    : m0_tag;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic win;
    logic expired;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        atomic_d = atomic_q;
        tout_d   = '0;
        win      = 1'b0;
        expired  = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT - 1));

        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req)
                        win = RR ? ~last_q : 1'b0;   // tie: not-last-winner, or m0
                    else
                        win = m1_req;
                    owner_d = win;
                    last_d  = win;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (!sel_req) begin
                    state_d = IDLE;                   // owner abandoned before astb
                end else if (sel_astb) begin
                    state_d  = DATA;
                    atomic_d = sel_atomic;
                end
            end
            DATA: begin
                // rd and wr together count as a write, so the bus is released.
                if (sel_wr)
                    state_d = IDLE;
                else if (sel_rd)
                    state_d = atomic_q ? LOCK : IDLE;
            end
            LOCK: begin
                // Only wr (or the time-out) releases a locked bus.
                if (sel_wr)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (expired) begin
            state_d         = IDLE;
            tout_d[owner_q] = 1'b1;
        end

        cnt_d = ((state_q == IDLE) || (state_d != state_q)) ? '0 : cnt_q + CW'(1);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;      // makes m0 the preferred master after reset
            atomic_q <= 1'b0;
            cnt_q    <= '0;
            tout_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            atomic_q <= atomic_d;
            cnt_q    <= cnt_d;
            tout_q   <= tout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    logic busy, in_addr, in_data;

    always_comb begin
        busy     = (state_q != IDLE);
        in_addr  = (state_q == ADDR);
        in_data  = (state_q == DATA) || (state_q == LOCK);

        o_busy   = busy;
        o_ad     = busy ? sel_ad  : '0;
        o_tag    = busy ? sel_tag : '0;
        o_astb   = in_addr && sel_astb;
        o_atomic = in_addr && sel_astb && sel_atomic;
        o_rd     = in_data && sel_rd;
        o_wr     = in_data && sel_wr;

        m0_gnt     = busy && !owner_q;
        m1_gnt     = busy &&  owner_q;
        m0_timeout = tout_q[0];
        m1_timeout = tout_q[1];
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_membus_arbiter
//
// Two arbiters side by side: u_rr (RR=1) and u_fp (RR=0), both TIMEOUT=16,
// each with its own set of master inputs. Directed steps cover the basic read,
// the atomic lock, the time-out, alternation versus fixed priority and the
// asynchronous reset. A random phase then has each master issue transactions
// built from the bus rules (phase-by-phase scripts) and checks every cycle
// against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_membus_arbiter;

    localparam int TOUT = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Inputs indexed [dut][master]
    logic [1:0]  req [2];
    logic [1:0]  astb [2];
    logic [1:0]  atomic [2];
    logic [1:0]  rd [2];
    logic [1:0]  wr [2];
    logic [63:0] ad [2][2];
    logic [7:0]  tag [2][2];

    // Outputs indexed [dut]
    logic [1:0]  gnt [2];
    logic [1:0]  tout [2];
    logic [63:0] o_ad [2];
    logic [7:0]  o_tag [2];
    logic [1:0]  o_astb, o_atomic, o_rd, o_wr, o_busy;

    membus_arbiter #(.TIMEOUT(TOUT), .RR(1'b1)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .m0_req(req[0][0]), .m0_ad(ad[0][0]), .m0_tag(tag[0][0]), .m0_astb(astb[0][0]),
        .m0_atomic(atomic[0][0]), .m0_rd(rd[0][0]), .m0_wr(wr[0][0]),
        .m0_gnt(gnt[0][0]), .m0_timeout(tout[0][0]),
        .m1_req(req[0][1]), .m1_ad(ad[0][1]), .m1_tag(tag[0][1]), .m1_astb(astb[0][1]),
        .m1_atomic(atomic[0][1]), .m1_rd(rd[0][1]), .m1_wr(wr[0][1]),
        .m1_gnt(gnt[0][1]), .m1_timeout(tout[0][1]),
        .o_ad(o_ad[0]), .o_tag(o_tag[0]), .o_astb(o_astb[0]), .o_atomic(o_atomic[0]),
        .o_rd(o_rd[0]), .o_wr(o_wr[0]), .o_busy(o_busy[0])
    );

    membus_arbiter #(.TIMEOUT(TOUT), .RR(1'b0)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_req(req[1][0]), .m0_ad(ad[1][0]), .m0_tag(tag[1][0]), .m0_astb(astb[1][0]),
        .m0_atomic(atomic[1][0]), .m0_rd(rd[1][0]), .m0_wr(wr[1][0]),
        .m0_gnt(gnt[1][0]), .m0_timeout(tout[1][0]),
        .m1_req(req[1][1]), .m1_ad(ad[1][1]), .m1_tag(tag[1][1]), .m1_astb(astb[1][1]),
        .m1_atomic(atomic[1][1]), .m1_rd(rd[1][1]), .m1_wr(wr[1][1]),
        .m1_gnt(gnt[1][1]), .m1_timeout(tout[1][1]),
        .o_ad(o_ad[1]), .o_tag(o_tag[1]), .o_astb(o_astb[1]), .o_atomic(o_atomic[1]),
        .o_rd(o_rd[1]), .o_wr(o_wr[1]), .o_busy(o_busy[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [8:0] ctl(input int d);
        return {o_busy[d], gnt[d], tout[d], o_astb[d], o_atomic[d], o_rd[d], o_wr[d]};
    endfunction

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; astb[d] = '0; atomic[d] = '0; rd[d] = '0; wr[d] = '0;
            for (int m = 0; m < 2; m++) begin
                ad[d][m]  = '0;
                tag[d][m] = '0;
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: each granted master plays a script of cycles, one per
    // bus cycle, carrying what it drives and what memory must see.
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic        rq, sa, sat, srd, swr;   // driven by owner
        logic        ea, eat, erd, ewr;       // expected at memory
        logic        last;                    // bus released after this cycle
        logic        tout;                    // release is a time-out
        logic [63:0] a;
        logic [7:0]  t;
    } step_t;

    step_t      scr [2][64];
    int         s_len [2];
    int         s_pos [2];
    bit         m_busy [2];
    int         m_owner [2];
    int         m_last [2];
    bit [1:0]   m_pulse [2];
    bit [1:0]   want [2];

    task automatic push(input int d, input bit rq, sa, sat, srd, swr, ea, eat, erd, ewr);
        step_t st;
        st = '0;
        st.rq = rq; st.sa = sa; st.sat = sat; st.srd = srd; st.swr = swr;
        st.ea = ea; st.eat = eat; st.erd = erd; st.ewr = ewr;
        st.a = {$urandom, $urandom};
        st.t = 8'($urandom);
        scr[d][s_len[d]] = st;
        s_len[d]++;
    endtask

    task automatic finish_script(input int d, input bit timed_out);
        scr[d][s_len[d]-1].last = 1'b1;
        scr[d][s_len[d]-1].tout = timed_out;
    endtask

    // kinds: 0 read, 1 write, 2 atomic, 3 atomic with rd+wr, 4 abandon,
    //        5 stall before astb, 6 stall in lock
    task automatic build(input int d);
        int  r, kind;
        bit  at, n;
        r = $urandom_range(99);
        kind = (r < 30) ? 0 : (r < 55) ? 1 : (r < 75) ? 2 : (r < 83) ? 3 :
               (r < 90) ? 4 : (r < 95) ? 5 : 6;
        s_len[d] = 0;
        s_pos[d] = 0;
        if (kind == 5) begin
            for (int i = 0; i < TOUT; i++) begin
                n = 1'($urandom_range(1));
                push(d, 1, 0, 0, n, 0, 0, 0, 0, 0);
            end
            finish_script(d, 1'b1);
            return;
        end
        for (int i = $urandom_range(3); i > 0; i--) begin
            n = 1'($urandom_range(1));
            push(d, 1, 0, n, n, 0, 0, 0, 0, 0);     // rd/atomic noise before astb
        end
        if (kind == 4) begin
            push(d, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            finish_script(d, 1'b0);
            return;
        end
        at = (kind == 2) || (kind == 3) || (kind == 6);
        push(d, 1, 1, at, 0, 0, 1, at, 0, 0);
        for (int i = $urandom_range(3); i > 0; i--) begin
            n = 1'($urandom_range(1));
            push(d, 1, n, 0, 0, 0, 0, 0, 0, 0);     // astb noise after address
        end
        case (kind)
            0: push(d, 1, 0, 0, 1, 0, 0, 0, 1, 0);
            1: push(d, 1, 0, 0, 0, 1, 0, 0, 0, 1);
            3: push(d, 1, 0, 0, 1, 1, 0, 0, 1, 1);
            default: begin
                push(d, 1, 0, 0, 1, 0, 0, 0, 1, 0);
                for (int i = (kind == 6) ? TOUT : $urandom_range(3); i > 0; i--) begin
                    bit q;
                    q = 1'($urandom_range(1));
                    n = 1'($urandom_range(1));
                    push(d, q, 0, 0, n, 0, 0, 0, n, 0);
                end
                if (kind == 2) begin
                    n = 1'($urandom_range(1));
                    push(d, 1, 0, 0, n, 1, 0, 0, n, 1);
                end
            end
        endcase
        finish_script(d, kind == 6);
    endtask

    task automatic model_drive(input int d);
        step_t st;
        for (int m = 0; m < 2; m++) begin
            if (m_busy[d] && m_owner[d] == m) begin
                st = scr[d][s_pos[d]];
                req[d][m] = st.rq; astb[d][m] = st.sa; atomic[d][m] = st.sat;
                rd[d][m] = st.srd; wr[d][m] = st.swr; ad[d][m] = st.a; tag[d][m] = st.t;
            end else begin
                req[d][m]    = want[d][m];
                astb[d][m]   = 1'($urandom_range(1));
                atomic[d][m] = 1'($urandom_range(1));
                rd[d][m]     = 1'($urandom_range(1));
                wr[d][m]     = 1'($urandom_range(1));
                ad[d][m]     = {$urandom, $urandom};
                tag[d][m]    = 8'($urandom);
            end
        end
    endtask

    task automatic model_check(input int d);
        step_t       st;
        logic [8:0]  e_ctl;
        logic [63:0] e_ad;
        logic [7:0]  e_tag;
        e_ctl = {5'b0, m_pulse[d], 2'b0} << 2;
        e_ctl = {3'b0, m_pulse[d], 4'b0};
        e_ad  = '0;
        e_tag = '0;
        if (m_busy[d]) begin
            st    = scr[d][s_pos[d]];
            e_ctl = {1'b1, (m_owner[d] == 1) ? 2'b10 : 2'b01, m_pulse[d],
                     st.ea, st.eat, st.erd, st.ewr};
            e_ad  = st.a;
            e_tag = st.t;
        end
        check($sformatf("rand_ctl_dut%0d", d), 64'(ctl(d)), 64'(e_ctl));
        check($sformatf("rand_ad_dut%0d", d), o_ad[d], e_ad);
        check($sformatf("rand_tag_dut%0d", d), 64'(o_tag[d]), 64'(e_tag));
    endtask

    task automatic model_advance(input int d);
        bit [1:0] np;
        int       w;
        np = '0;
        if (m_busy[d]) begin
            if (scr[d][s_pos[d]].last) begin
                m_busy[d] = 1'b0;
                if (scr[d][s_pos[d]].tout) np[m_owner[d]] = 1'b1;
                want[d][m_owner[d]] = 1'b0;
            end else begin
                s_pos[d]++;
            end
        end else if (want[d] != 2'b00) begin
            // Tie: round-robin gives it to the master that did not win last;
            // fixed priority gives it to m0. A lone requester always wins.
            if (want[d] == 2'b11) w = (d == 0) ? 1 - m_last[d] : 0;
            else                  w = want[d][1] ? 1 : 0;
            m_busy[d]  = 1'b1;
            m_owner[d] = w;
            m_last[d]  = w;
            build(d);
        end
        m_pulse[d] = np;
        for (int m = 0; m < 2; m++)
            if (!want[d][m] && $urandom_range(99) < 30) want[d][m] = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        clear_inputs();
        reset_n = 1'b0;
        repeat (3) tick();
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_ctl_dut%0d", d), 64'(ctl(d)), 64'd0);
            check($sformatf("reset_ad_dut%0d", d), o_ad[d], 64'd0);
        end

        // ---- Basic read by m0 (cycle 0 = first cycle out of reset) ----
        tick();
        reset_n   = 1'b1;
        req[0][0] = 1'b1;
        #1 check("t1_gnt_c0", 64'(gnt[0]), 64'b00);
        tick(); #1 check("t1_gnt_c1", 64'(gnt[0]), 64'b01);
        tick();
        astb[0][0] = 1'b1; ad[0][0] = 64'h40000; tag[0][0] = 8'h5a;
        #1;
        check("t1_astb_c2", 64'(o_astb[0]), 64'd1);
        check("t1_ad_c2", o_ad[0], 64'h40000);
        check("t1_tag_c2", 64'(o_tag[0]), 64'h5a);
        tick();
        astb[0][0] = 1'b0; rd[0][0] = 1'b1;
        #1;
        check("t1_rd_c3", 64'(o_rd[0]), 64'd1);
        check("t1_astb_gated_c3", 64'(o_astb[0]), 64'd0);
        tick();
        rd[0][0] = 1'b0; req[0][0] = 1'b0;
        tick(); #1;
        check("t1_gnt_c5", 64'(gnt[0]), 64'b00);
        check("t1_busy_c5", 64'(o_busy[0]), 64'd0);

        // ---- m1 atomic: bus stays locked while m1 drops req ----
        req[0][1] = 1'b1;
        tick();
        astb[0][1] = 1'b1; atomic[0][1] = 1'b1; ad[0][1] = 64'h1234;
        #1;
        check("t3_gnt_m1", 64'(gnt[0]), 64'b10);
        check("t3_astb_atomic", 64'({o_astb[0], o_atomic[0]}), 64'b11);
        check("t3_ad", o_ad[0], 64'h1234);
        tick();
        astb[0][1] = 1'b0; atomic[0][1] = 1'b0; rd[0][1] = 1'b1;
        #1 check("t3_rd", 64'(o_rd[0]), 64'd1);
        tick();
        rd[0][1] = 1'b0; req[0][1] = 1'b0; req[0][0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1 check($sformatf("t3_lock_hold_%0d", i), 64'(gnt[0]), 64'b10);
            tick();
        end
        wr[0][1] = 1'b1;
        #1 check("t3_wr", 64'({o_wr[0], gnt[0]}), 64'b110);
        tick();
        wr[0][1] = 1'b0;
        #1 check("t3_idle_after_wr", 64'(gnt[0]), 64'b00);
        tick();
        #1 check("t3_m0_gnt_2_after_wr", 64'(gnt[0]), 64'b01);

        // ---- m0 never strobes: time-out, then pending m1 granted ----
        req[0][1] = 1'b1;
        for (int k = 1; k <= 15; k++) tick();
        #1 check("t4_before_timeout", 64'({tout[0], gnt[0]}), 64'b0001);
        tick();
        #1;
        check("t4_timeout_pulse", 64'(tout[0]), 64'b01);
        check("t4_gnt_dropped", 64'(gnt[0]), 64'b00);
        req[0][0] = 1'b0;
        tick();
        #1;
        check("t4_pulse_one_cycle", 64'(tout[0]), 64'b00);
        check("t4_m1_granted", 64'(gnt[0]), 64'b10);
        req[0][1] = 1'b0;                          // abandon in ADDR
        tick(); tick();
        #1 check("t4_abandon_idle", 64'(o_busy[0]), 64'd0);

        // ---- Both masters request continuously: RR alternates, FP stays m0 ----
        req[0] = 2'b11; req[1] = 2'b11;
        for (int t = 0; t < 4; t++) begin
            tick();
            #1;
            check($sformatf("t2_rr_grant_%0d", t), 64'(gnt[0]), (t % 2 == 0) ? 64'b01 : 64'b10);
            check($sformatf("t2_fp_grant_%0d", t), 64'(gnt[1]), 64'b01);
            astb[0] = 2'b11; astb[1] = 2'b11;
            tick();
            astb[0] = 2'b00; astb[1] = 2'b00; rd[0] = 2'b11; rd[1] = 2'b11;
            #1 check($sformatf("t2_rd_%0d", t), 64'(o_rd), 64'b11);
            tick();
            rd[0] = 2'b00; rd[1] = 2'b00;
            #1 check($sformatf("t2_idle_gap_%0d", t), 64'(o_busy), 64'b00);
        end
        req[0] = 2'b00; req[1] = 2'b00;
        tick();

        // ---- Reset in DATA: outputs drop at once, m0 preferred afterwards ----
        req[0][0] = 1'b1;
        tick();
        astb[0][0] = 1'b1; ad[0][0] = 64'h55;
        tick();
        astb[0][0] = 1'b0; rd[0][0] = 1'b1;
        #1 check("t6_rd_before_reset", 64'(o_rd[0]), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_ctl_async", 64'(ctl(0)), 64'd0);
        check("t6_ad_async", o_ad[0], 64'd0);
        rd[0][0] = 1'b0; req[0] = 2'b11;
        tick();
        reset_n = 1'b1;
        tick();
        #1 check("t6_m0_first", 64'(gnt[0]), 64'b01);
        req[0] = 2'b00;

        // ---- Random transactions against the reference model ----
        reset_n = 1'b0;
        clear_inputs();
        tick();
        reset_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0; m_owner[d] = 0; m_last[d] = 1;
            m_pulse[d] = '0; want[d] = '0; s_len[d] = 0; s_pos[d] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) model_drive(d);
            #1;
            for (int d = 0; d < 2; d++) begin
                model_check(d);
                model_advance(d);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
